// File: rtl/debug_frame_tx_pkg.sv
// debug_frame_tx_pkg: shared constants and FSM encodings for the debug frame transmitter
package debug_frame_tx_pkg;
  localparam int DFT_UART_BITS = 8;
  localparam logic [7:0] DFT_SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {DFT_IDLE, DFT_SYNC, DFT_COUNT, DFT_INDEX, DFT_DATA, DFT_CHECK} dft_state_e;
endpackage

// File: rtl/debug_frame_tx_field_select_next.sv
// field_select_next: lowest set mask bit above idx, or at/above zero when first is set
module field_select_next #(
  parameter int N = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] idx,
  input  logic          first,
  output logic          found,
  output logic [IW-1:0] nxt
);
  always_comb begin
    found = 1'b0;
    nxt = '0;
    for (int k = N - 1; k >= 0; k--)
      if (mask[k] && (first || k > int'(idx))) begin
        found = 1'b1;
        nxt = IW'(k);
      end
  end
endmodule

// File: rtl/debug_frame_tx.sv
// debug_frame_tx: captures a masked field snapshot and streams it as a framed, XOR-checked byte sequence
module debug_frame_tx
  import debug_frame_tx_pkg::*;
#(
  parameter int NUM_FIELDS = 8,
  parameter int FIELD_BITS = 32,
  parameter int UART_BITS = DFT_UART_BITS,
  parameter logic [UART_BITS-1:0] SYNC_BYTE = DFT_SYNC_BYTE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [NUM_FIELDS-1:0]            i_field_mask,
  input  logic [NUM_FIELDS*FIELD_BITS-1:0] i_snapshot,
  output logic [UART_BITS-1:0]             o_tx_data,
  output logic                             o_tx_valid,
  input  logic                             i_tx_ready,
  output logic                             o_busy,
  output logic                             o_done
);
  localparam int BPF = (FIELD_BITS + 7) / 8;
  localparam int IW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam int BW = BPF > 1 ? $clog2(BPF) : 1;

  dft_state_e state, state_d;
  logic [NUM_FIELDS-1:0] mask_q;
  logic [NUM_FIELDS-1:0][FIELD_BITS-1:0] snap_q;
  logic [UART_BITS-1:0] count_q, chk_q, chk_d;
  logic [IW-1:0] idx_q, idx_d, nxt;
  logic [BW-1:0] byte_q, byte_d;
  logic [BPF-1:0][UART_BITS-1:0] fpad;
  logic found, fire, capture, done_d;

  function automatic logic [UART_BITS-1:0] popcount(input logic [NUM_FIELDS-1:0] m);
    popcount = '0;
    for (int k = 0; k < NUM_FIELDS; k++) popcount += UART_BITS'(m[k]);
  endfunction

  field_select_next #(.N(NUM_FIELDS), .IW(IW)) u_sel (
    .mask(mask_q), .idx(idx_q), .first(state == DFT_COUNT), .found(found), .nxt(nxt)
  );

  assign fpad = (BPF * UART_BITS)'(snap_q[idx_q]);
  assign o_tx_valid = state != DFT_IDLE;
  assign o_busy = state != DFT_IDLE;
  assign fire = o_tx_valid && i_tx_ready;
  assign o_tx_data = state == DFT_SYNC  ? SYNC_BYTE :
                     state == DFT_COUNT ? count_q :
                     state == DFT_INDEX ? UART_BITS'(idx_q) :
                     state == DFT_DATA  ? fpad[byte_q] :
                     state == DFT_CHECK ? chk_q : '0;

  always_comb begin
    state_d = state;
    idx_d = idx_q;
    byte_d = byte_q;
    chk_d = chk_q;
    done_d = 1'b0;
    capture = 1'b0;
    if (state == DFT_IDLE) begin
      capture = i_start;
      state_d = i_start ? DFT_SYNC : DFT_IDLE;
      chk_d = i_start ? '0 : chk_q;
    end else if (fire) begin
      chk_d = (state == DFT_SYNC || state == DFT_CHECK) ? chk_q : chk_q ^ o_tx_data;
      // COUNT and the last DATA byte both hand over to the next enabled field or CHECK
      unique case (state)
        DFT_SYNC: state_d = DFT_COUNT;
        DFT_COUNT, DFT_DATA:
          if (state == DFT_DATA && byte_q != BW'(BPF - 1)) byte_d = byte_q + 1'b1;
          else begin
            state_d = found ? DFT_INDEX : DFT_CHECK;
            idx_d = found ? nxt : idx_q;
          end
        DFT_INDEX: begin
          state_d = DFT_DATA;
          byte_d = '0;
        end
        DFT_CHECK: begin
          state_d = DFT_IDLE;
          done_d = 1'b1;
        end
        default: state_d = DFT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DFT_IDLE;
      mask_q <= '0;
      snap_q <= '0;
      count_q <= '0;
      idx_q <= '0;
      byte_q <= '0;
      chk_q <= '0;
      o_done <= 1'b0;
    end else begin
      state <= state_d;
      idx_q <= idx_d;
      byte_q <= byte_d;
      chk_q <= chk_d;
      o_done <= done_d;
      if (capture) begin
        mask_q <= i_field_mask;
        snap_q <= i_snapshot;
        count_q <= popcount(i_field_mask);
      end
    end
  end
endmodule

// File: tb/tb_debug_frame_tx.sv
// tb_debug_frame_tx: scoreboard bench for debug_frame_tx (4x16-bit and 4x12-bit instances)
module tb_debug_frame_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, ready = 1'b1, start12 = 1'b0;
  logic [3:0] mask = '0, mask12 = '0;
  logic [63:0] snap = '0;
  logic [47:0] snap12 = '0;
  logic [7:0] data, data12;
  logic valid, busy, done, valid12, busy12, done12;
  logic [7:0] q[$];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  debug_frame_tx #(.NUM_FIELDS(4), .FIELD_BITS(16)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_field_mask(mask), .i_snapshot(snap),
    .o_tx_data(data), .o_tx_valid(valid), .i_tx_ready(ready), .o_busy(busy), .o_done(done)
  );

  debug_frame_tx #(.NUM_FIELDS(4), .FIELD_BITS(12)) dut12 (
    .clk(clk), .rst(rst), .i_start(start12), .i_field_mask(mask12), .i_snapshot(snap12),
    .o_tx_data(data12), .o_tx_valid(valid12), .i_tx_ready(1'b1), .o_busy(busy12), .o_done(done12)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] m, input logic [63:0] s, input int fb, output int len);
    int bpf;
    logic [7:0] c, b;
    logic [63:0] fv;
    bpf = (fb + 7) / 8;
    c = 8'($countones(m));
    q.push_back(8'hA5);
    q.push_back(c);
    for (int k = 0; k < 4; k++)
      if (m[k]) begin
        q.push_back(8'(k));
        c ^= 8'(k);
        fv = (s >> (k * fb)) & ((64'd1 << fb) - 64'd1);
        for (int i = 0; i < bpf; i++) begin
          b = 8'(fv >> (8 * i));
          q.push_back(b);
          c ^= b;
        end
      end
    q.push_back(c);
    len = 3 + $countones(m) * (1 + bpf);
  endtask

  bit hold = 0, exp_done = 0;
  logic [7:0] hold_data;
  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
      exp_done = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", valid, 1);
        chk("hold_data", data, hold_data);
      end
      if (done || exp_done) begin
        chk("done_pulse", done, exp_done);
        chk("busy_at_done", busy, 0);
      end
      exp_done = 0;
      if (valid && ready) begin
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("tx_byte", data, q.pop_front());
          exp_done = q.size() == 0;
        end
      end
      hold = valid && !ready;
      hold_data = data;
    end
  end

  task automatic run_frame(input logic [3:0] m, input logic [63:0] s, input int stall_at,
                           input int stall_len, input bit disturb);
    int len, cyc;
    push_frame(m, s, 16, len);
    start = 1;
    mask = m;
    snap = s;
    @(posedge clk);
    #1 start = 0;
    cyc = 0;
    fork
      begin
        if (stall_at >= 0) begin
          repeat (stall_at) @(posedge clk);
          #1 ready = 0;
          repeat (stall_len) @(posedge clk);
          #1 ready = 1;
        end
      end
      begin
        if (disturb) begin
          @(posedge clk);
          #1 start = 1;
          mask = 4'hF;
          snap = {$urandom, $urandom};
          @(posedge clk);
          #1 start = 0;
        end
      end
      begin
        while (!done && cyc < 200) begin
          @(posedge clk);
          #1 cyc++;
        end
      end
    join
    chk("frame_cycles", cyc, len + (stall_at >= 0 ? stall_len : 0));
  endtask

  initial begin
    int len;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    run_frame(4'b0101, 64'h0000_BEEF_0000_1234, -1, 0, 0);
    run_frame(4'b0000, 64'h0123_4567_89AB_CDEF, -1, 0, 0);
    run_frame(4'b0101, 64'h0000_BEEF_0000_1234, 3, 3, 0);
    run_frame(4'b0101, 64'h5555_6666_7777_8888, -1, 0, 1);
    run_frame(4'b1111, 64'hDEAD_BEEF_CAFE_F00D, 5, 2, 0);
    run_frame(4'b1010, 64'h1357_9BDF_2468_ACE0, -1, 0, 0);
    push_frame(4'b0001, 64'hABC, 12, len);
    start12 = 1;
    mask12 = 4'b0001;
    snap12 = 48'hFFF_FFF_FFF_ABC;
    @(posedge clk);
    #1 start12 = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk("d12_valid", valid12, 1);
      chk("d12_byte", data12, q.pop_front());
    end
    @(negedge clk);
    chk("d12_done", done12, 1);
    chk("d12_busy", busy12, 0);
    @(posedge clk);
    #1 push_frame(4'b0101, 64'h0000_BEEF_0000_1234, 16, len);
    start = 1;
    mask = 4'b0101;
    snap = 64'h0000_BEEF_0000_1234;
    @(posedge clk);
    #1 start = 0;
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_valid", valid, 1);
    chk("pre_rst_index", data, 8'h00);
    rst = 1;
    @(posedge clk);
    #1 chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 0;
    q.delete();
    run_frame(4'b0110, 64'h0000_4321_8765_0000, -1, 0, 0);
    repeat (3) @(posedge clk);
    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule
